// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block: alignment mode, count direction, channel limit.
package pwm_pkg;

  localparam int PWM_MAX_CH = 16;

  typedef enum logic {
    PWM_MODE_EDGE   = 1'b0,
    PWM_MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    PWM_DIR_UP   = 1'b0,
    PWM_DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage : pwm_pkg

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed compare value, counter compare, polarity and registered output.
module pwm_channel #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] cmp_i,
  input  logic [W-1:0] cnt_i,
  input  logic         polarity_i,
  output logic         pwm_o
);

  logic [W-1:0] cmp_q, cmp_d;
  logic         pwm_q, pwm_d;

  assign cmp_d = load_i ? cmp_i : cmp_q;
  // Polarity is deliberately not shadowed; it takes effect on the very next output load.
  assign pwm_d = (cnt_i < cmp_q) ^ polarity_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule : pwm_channel

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared edge/center-aligned counter and shadowed period/mode/compares.
// Optional sticky period interrupt (irq_o, irq_clr_i) when PWM_MULTI_PERIOD_IRQ_EN is defined.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable_i,
  input  logic                            tick_i,
  input  logic                            mode_i,
  input  logic [COUNTER_WIDTH-1:0]        period_i,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0] cmp_i,
  input  logic [NUM_CH-1:0]               polarity_i,
`ifdef PWM_MULTI_PERIOD_IRQ_EN
  input  logic                            irq_clr_i,
  output logic                            irq_o,
`endif
  output logic                            period_start_o,
  output logic [NUM_CH-1:0]               pwm_o
);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  cnt_t      cnt_q, cnt_d;
  cnt_t      period_q, period_d, period_eff;
  pwm_mode_e mode_q, mode_d, mode_eff;
  pwm_dir_e  dir_q, dir_d;
  logic      period_start_q, period_start_d;
  logic      update, load;

  assign update = enable_i && tick_i && (cnt_q == '0);
  // While disabled the shadows track the inputs so the first period starts with fresh values.
  assign load   = !enable_i || update;

  // On the update tick the step already follows the newly loaded mode and period.
  assign mode_eff   = update ? pwm_mode_e'(mode_i) : mode_q;
  assign period_eff = update ? period_i : period_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    mode_d         = load ? pwm_mode_e'(mode_i) : mode_q;
    period_d       = load ? period_i : period_q;
    period_start_d = update;

    if (!enable_i) begin
      cnt_d = '0;
      dir_d = PWM_DIR_UP;
    end else if (tick_i) begin
      if (mode_eff == PWM_MODE_EDGE) begin
        dir_d = PWM_DIR_UP;
        cnt_d = (cnt_q >= period_eff) ? '0 : cnt_q + CNT_ONE;
      end else if (update || dir_q == PWM_DIR_UP) begin
        if (cnt_q >= period_eff) begin
          if (period_eff == '0) begin
            cnt_d = '0;
            dir_d = PWM_DIR_UP;
          end else begin
            cnt_d = period_eff - CNT_ONE;
            dir_d = PWM_DIR_DOWN;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          dir_d = PWM_DIR_UP;
        end
      end else begin
        // Counting down never sees zero here: zero with a tick is always an update.
        cnt_d = cnt_q - CNT_ONE;
        dir_d = PWM_DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    if (rst) begin
      cnt_q          <= '0;
      dir_q          <= PWM_DIR_UP;
      mode_q         <= PWM_MODE_EDGE;
      period_q       <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      period_q       <= period_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start_o = period_start_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    pwm_channel #(
      .W(COUNTER_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .cmp_i      (cmp_i[n*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .cnt_i      (cnt_q),
      .polarity_i (polarity_i[n]),
      .pwm_o      (pwm_o[n])
    );
  end

`ifdef PWM_MULTI_PERIOD_IRQ_EN
  logic irq_q, irq_d;

  // Set has priority so an update coinciding with a clear is never lost.
  assign irq_d = update ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`endif

endmodule : pwm_multi

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period-phase reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_pwm_multi;

  localparam int NCH = 4;
  localparam int CW  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              tick;
  logic              mode;
  logic [CW-1:0]     period;
  logic [CW-1:0]     cmp_a [NCH];
  logic [NCH*CW-1:0] cmp_bus;
  logic [NCH-1:0]    pol;
  logic              period_start;
  logic [NCH-1:0]    pwm;
`ifdef PWM_MULTI_PERIOD_IRQ_EN
  logic              irq_clr;
  logic              irq;
`endif

  always #5 clk = ~clk;

  always_comb begin
    cmp_bus = '0;
    for (int n = 0; n < NCH; n++) cmp_bus[n*CW +: CW] = cmp_a[n];
  end

  pwm_multi #(
    .NUM_CH        (NCH),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .tick_i         (tick),
    .mode_i         (mode),
    .period_i       (period),
    .cmp_i          (cmp_bus),
    .polarity_i     (pol),
`ifdef PWM_MULTI_PERIOD_IRQ_EN
    .irq_clr_i      (irq_clr),
    .irq_o          (irq),
`endif
    .period_start_o (period_start),
    .pwm_o          (pwm)
  );

  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic           ps;
    logic           irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: position k within the current period plus the latched period settings.
  int m_k;
  int m_per;
  int m_mode;
  int m_cmp [NCH];
  bit m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int cnt_of(input int k, input int p, input int md);
    if (md == 0) return k;
    return (k <= p) ? k : 2 * p - k;
  endfunction

  function automatic int period_len(input int p, input int md);
    if (md == 0) return p + 1;
    return (p == 0) ? 1 : 2 * p;
  endfunction

  task automatic latch_settings();
    m_per  = int'(period);
    m_mode = int'(mode);
    for (int n = 0; n < NCH; n++) m_cmp[n] = int'(cmp_a[n]);
  endtask

  // Predict the outputs after the coming clock edge, then let that edge happen.
  task automatic step();
    exp_t e;
    int   c;
    bit   upd;
    e = '0;
    if (rst) begin
      m_k = 0; m_per = 0; m_mode = 0; m_irq = 1'b0;
      for (int n = 0; n < NCH; n++) m_cmp[n] = 0;
    end else begin
      c = cnt_of(m_k, m_per, m_mode);
      for (int n = 0; n < NCH; n++) e.pwm[n] = (c < m_cmp[n]) ^ pol[n];
      upd  = enable && tick && (c == 0);
      e.ps = upd;
      if (!enable) begin
        m_k = 0;
        latch_settings();
      end else if (tick) begin
        if (upd) latch_settings();
        m_k = (m_k + 1) % period_len(m_per, m_mode);
      end
`ifdef PWM_MULTI_PERIOD_IRQ_EN
      if (upd) m_irq = 1'b1;
      else if (irq_clr) m_irq = 1'b0;
`endif
      e.irq = m_irq;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwm_o", 32'(pwm), 32'(e.pwm));
        check("period_start_o", 32'(period_start), 32'(e.ps));
`ifdef PWM_MULTI_PERIOD_IRQ_EN
        check("irq_o", 32'(irq), 32'(e.irq));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; mode = 1'b0; period = '0; pol = '0;
    for (int n = 0; n < NCH; n++) cmp_a[n] = '0;
`ifdef PWM_MULTI_PERIOD_IRQ_EN
    irq_clr = 1'b0;
`endif
    m_k = 0; m_per = 0; m_mode = 0; m_irq = 1'b0;
    for (int n = 0; n < NCH; n++) m_cmp[n] = 0;

    // Reset state
    repeat (3) step();
    rst = 1'b0;

    // Edge mode, period 9, channel 0 at 3/10 with continuous ticks
    period = 10'd9; cmp_a[0] = 10'd3; cmp_a[1] = 10'd5;
    repeat (2) step();
    enable = 1'b1; tick = 1'b1;
    repeat (32) step();

    // Center mode, period 4, compare 2
    enable = 1'b0; mode = 1'b1; period = 10'd4; cmp_a[0] = 10'd2;
    step();
    enable = 1'b1;
    repeat (26) step();

    // Compare extremes: 0 gives never active, above period gives always active (inverted)
    enable = 1'b0; mode = 1'b0; period = 10'd9; cmp_a[0] = '0; cmp_a[1] = 10'd11;
    pol = 4'b0010;
    step();
    enable = 1'b1;
    repeat (25) step();

    // Mid-period compare change takes effect only at the next update
    enable = 1'b0; pol = '0; cmp_a[0] = 10'd3;
    step();
    enable = 1'b1;
    repeat (5) step();
    cmp_a[0] = 10'd7;
    repeat (25) step();

    // Zero period in both modes: every tick is an update
    enable = 1'b0; period = '0; cmp_a[0] = 10'd1;
    step();
    enable = 1'b1;
    repeat (6) step();
    enable = 1'b0; mode = 1'b1;
    step();
    enable = 1'b1;
    repeat (6) step();

    // Reset mid-period, then sparse ticks every fourth cycle
    enable = 1'b0; mode = 1'b0; period = 10'd9; cmp_a[0] = 10'd3;
    step();
    enable = 1'b1;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick = (i % 4 == 0);
      step();
    end

`ifdef PWM_MULTI_PERIOD_IRQ_EN
    // Clear held across an update: set wins; clear alone drops irq
    tick = 1'b1; irq_clr = 1'b1;
    repeat (12) step();
    irq_clr = 1'b0;
`endif

    // Randomized operation with mid-period setting changes
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(299) == 0);
      enable = ($urandom_range(59) != 0);
      tick   = ($urandom_range(2) != 0);
      if ($urandom_range(19) == 0) period = CW'($urandom_range(12));
      if ($urandom_range(39) == 0) mode = 1'($urandom_range(1));
      if ($urandom_range(9) == 0) cmp_a[$urandom_range(NCH-1)] = CW'($urandom_range(15));
      if ($urandom_range(29) == 0) pol = NCH'($urandom_range(15));
`ifdef PWM_MULTI_PERIOD_IRQ_EN
      irq_clr = ($urandom_range(7) == 0);
`endif
      step();
    end

    rst = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pwm_multi
